serial_adder_ctrl: RTL and testbench

//   Bit-serial add controller: sequences one 1-bit adder cell (two HalfAdder

---
 rtl/serial_adder_ctrl.sv | 130 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell iterated WIDTH times.
// Optional subtract mode enabled by defining SERIAL_ADD_SUB_EN.
module serial_adder_ha (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             Sub,
`endif
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sha;
  logic [WIDTH-1:0] r_shb;
  logic             r_carry;
  logic [CNTW-1:0]  r_cnt;

  logic             w_s0;
  logic             w_c0;
  logic             w_c1;
  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_bload;
  logic             w_cin;

`ifdef SERIAL_ADD_SUB_EN
  // Subtract as A + ~B + 1; carry-out high means no borrow.
  assign w_bload = Sub ? ~B : B;
  assign w_cin   = Sub;
`else
  assign w_bload = B;
  assign w_cin   = 1'b0;
`endif

  serial_adder_ha u_ha0 (
    .i_a (r_sha[0]),
    .i_b (r_shb[0]),
    .o_s (w_s0),
    .o_c (w_c0)
  );

  serial_adder_ha u_ha1 (
    .i_a (w_s0),
    .i_b (r_carry),
    .o_s (w_sum),
    .o_c (w_c1)
  );

  assign w_cout = w_c0 | w_c1;

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      r_state <= S_IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Sum     <= '0;
      Cout    <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sha   <= '0;
      r_shb   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            r_sha   <= A;
            r_shb   <= w_bload;
            r_carry <= w_cin;
            r_cnt   <= '0;
            Sum     <= '0;
            Cout    <= 1'b0;
            Busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          Sum     <= {w_sum, Sum[WIDTH-1:1]};
          r_sha   <= {1'b0, r_sha[WIDTH-1:1]};
          r_shb   <= {1'b0, r_shb[WIDTH-1:1]};
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CNTW'(1);
          if (r_cnt == LAST) begin
            Cout    <= w_cout;
            Busy    <= 1'b0;
            Done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          Done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          Busy    <= 1'b0;
          Done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomised bench for serial_adder_ctrl against an arithmetic model.
// Subtract checks compile in when SERIAL_ADD_SUB_EN is defined.
module tb_serial_adder_ctrl;

  localparam int W = 8;
  localparam longint MASK = (64'd1 << W) - 1;

  logic         CLK = 1'b0;
  logic         Reset_L = 1'b0;
  logic         Start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Sub = 1'b0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Sum;
  logic         Cout;

  int n_chk = 0;
  int n_fail = 0;

  serial_adder_ctrl #(.WIDTH(W), .CNTW(4)) dut (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .Start   (Start),
    .A       (A),
    .B       (B),
`ifdef SERIAL_ADD_SUB_EN
    .Sub     (Sub),
`endif
    .Busy    (Busy),
    .Done    (Done),
    .Sum     (Sum),
    .Cout    (Cout)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 running, 2 done; m_k = result bits produced.
  int     m_ph = 0;
  int     m_k = 0;
  longint m_res = 0;
  longint m_sum = 0;
  bit     m_cout = 1'b0;
  bit     m_valid = 1'b0;

  always @(posedge CLK) begin
    longint bb;
    longint cin;
    int     k;
    if (!Reset_L) begin
      m_ph    <= 0;
      m_k     <= 0;
      m_sum   <= 0;
      m_cout  <= 1'b0;
      m_valid <= 1'b1;
    end else if (m_ph == 0) begin
      if (Start) begin
`ifdef SERIAL_ADD_SUB_EN
        cin = longint'(Sub);
`else
        cin = 0;
`endif
        bb = (cin != 0) ? (~longint'(B)) & MASK : longint'(B);
        m_res  <= longint'(A) + bb + cin;
        m_k    <= 0;
        m_sum  <= 0;
        m_cout <= 1'b0;
        m_ph   <= 1;
      end
    end else if (m_ph == 1) begin
      k = m_k + 1;
      m_k   <= k;
      m_sum <= ((m_res & ((64'd1 << k) - 1)) << (W - k)) & MASK;
      if (k == W) begin
        m_cout <= m_res[W];
        m_ph   <= 2;
      end
    end else begin
      m_ph <= 0;
    end
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("busy", longint'(Busy), longint'(m_ph == 1));
      chk("done", longint'(Done), longint'(m_ph == 2));
      chk("sum", longint'(Sum), m_sum);
      chk("cout", longint'(Cout), longint'(m_cout));
      chk("busy_done_excl", longint'(Busy & Done), 0);
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input bit hold, input bit mut,
                        output logic [W-1:0] s, output logic c,
                        output int bc, output int dc);
    bit seen;
    bc = 0;
    dc = 0;
    seen = 1'b0;
    s = '0;
    c = 1'b0;
    @(posedge CLK);
    #1;
    A = a;
    B = b;
    Sub = sub;
    Start = 1'b1;
    @(posedge CLK);
    #1;
    if (!hold) Start = 1'b0;
    if (mut) begin
      A = W'($urandom);
      B = W'($urandom);
      Sub = 1'($urandom);
    end
    for (int i = 0; i < W + 4; i++) begin
      @(negedge CLK);
      if (Busy) bc++;
      if (Done) begin
        dc++;
        s = Sum;
        c = Cout;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(posedge CLK);
    #1;
    Start = 1'b0;
    @(negedge CLK);
    if (Done) dc++;
  endtask

  initial begin
    logic [W-1:0] s;
    logic         c;
    int           bc;
    int           dc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    longint       exp;

    Reset_L = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", longint'(Busy), 0);
    chk("rst_done", longint'(Done), 0);
    chk("rst_sum", longint'(Sum), 0);
    chk("rst_cout", longint'(Cout), 0);
    #1;
    Reset_L = 1'b1;

    run_op(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, s, c, bc, dc);
    chk("z_busy_cycles", bc, 8);
    chk("z_done_cnt", dc, 1);
    chk("z_sum", longint'(s), 64'h00);
    chk("z_cout", longint'(c), 0);

    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, s, c, bc, dc);
    chk("ff01_sum", longint'(s), 64'h00);
    chk("ff01_cout", longint'(c), 1);

    run_op(8'hA5, 8'h5A, 1'b0, 1'b0, 1'b0, s, c, bc, dc);
    chk("a55a_sum", longint'(s), 64'hFF);
    chk("a55a_cout", longint'(c), 0);

    run_op(8'h03, 8'h04, 1'b0, 1'b1, 1'b1, s, c, bc, dc);
    chk("hold_sum", longint'(s), 64'h07);
    chk("hold_cout", longint'(c), 0);
    chk("hold_done_cnt", dc, 1);
    chk("hold_busy_cycles", bc, 8);
    @(negedge CLK);
    chk("hold_idle_after", longint'(Busy), 0);

`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h05, 8'h07, 1'b1, 1'b0, 1'b0, s, c, bc, dc);
    chk("sub57_sum", longint'(s), 64'hFE);
    chk("sub57_cout", longint'(c), 0);
    run_op(8'h07, 8'h05, 1'b1, 1'b0, 1'b0, s, c, bc, dc);
    chk("sub75_sum", longint'(s), 64'h02);
    chk("sub75_cout", longint'(c), 1);
    Sub = 1'b0;
`endif

    // Reset lands before the 4th RUN edge.
    @(posedge CLK);
    #1;
    A = 8'h3C;
    B = 8'h2B;
    Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    Reset_L = 1'b0;
    @(posedge CLK);
    #1;
    Reset_L = 1'b1;
    @(negedge CLK);
    chk("midrst_busy", longint'(Busy), 0);
    chk("midrst_sum", longint'(Sum), 0);
    chk("midrst_done", longint'(Done), 0);
    dc = 0;
    repeat (W + 3) begin
      @(negedge CLK);
      if (Done) dc++;
    end
    chk("midrst_no_done", dc, 0);

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, rs, 1'($urandom), 1'($urandom), s, c, bc, dc);
      if (rs) exp = longint'(ra) + ((~longint'(rb)) & MASK) + 1;
      else exp = longint'(ra) + longint'(rb);
      chk("rnd_result", {55'd0, c, s}, exp & ((MASK << 1) | 1));
      chk("rnd_done_cnt", dc, 1);
      Sub = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge CLK);
    end

    repeat (2) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
